// File: rtl/cache_array_if.sv
// Bus interface for cache_array: write/flush requests in, read data and status out.
interface cache_array_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  logic             write;
  logic [NB-1:0]    wmask;
  logic [IW-1:0]    index;
  logic [WIDTH-1:0] datain;
  logic             flush;
  logic [WIDTH-1:0] dataout;
  logic             valid_out;
  logic             busy;

  modport master (
    output write, wmask, index, datain, flush,
    input  dataout, valid_out, busy
  );

  modport slave (
    input  write, wmask, index, datain, flush,
    output dataout, valid_out, busy
  );
endinterface

// File: rtl/cache_array.sv
// cache_array: DEPTH x WIDTH byte-maskable storage with per-entry valid bits and a
// one-entry-per-cycle invalidate sweep. Optional macro CACHE_ARRAY_BYPASS_EN forwards
// accepted write lanes combinationally to dataout.
module cache_array #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  cache_array_if.slave  bus
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  typedef enum logic {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             wr_en;
  logic [WIDTH-1:0] wr_word;

  // Writes are dropped during a sweep and a zero mask is a no-op.
  assign wr_en = bus.write && !busy_q && (|bus.wmask);

  // Merge enabled lanes of datain over the stored word.
  always_comb begin
    wr_word = data_q[bus.index];
    for (int unsigned i = 0; i < NB; i++) begin
      if (bus.wmask[i]) wr_word[8*i +: 8] = bus.datain[8*i +: 8];
    end
  end

  // Data array next state.
  always_comb begin
    data_d = data_q;
    if (wr_en) data_d[bus.index] = wr_word;
  end

  // Valid bits and sweep FSM next state; the write lands before any sweep begins.
  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (wr_en) valid_d[bus.index] = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (bus.flush) begin
          state_d = StClear;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StClear: begin
        valid_d[cnt_q] = 1'b0;
        if (cnt_q == IW'(DEPTH - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM, counter, registered busy and valid bits; reset aborts any sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // Data storage is intentionally not reset; valid bits gate its visibility.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  // Combinational read port, with optional same-cycle write forwarding.
  always_comb begin
    bus.valid_out = valid_q[bus.index];
    bus.dataout   = valid_q[bus.index] ? data_q[bus.index] : '0;
`ifdef CACHE_ARRAY_BYPASS_EN
    if (wr_en) begin
      bus.valid_out = 1'b1;
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.wmask[i]) bus.dataout[8*i +: 8] = bus.datain[8*i +: 8];
      end
    end
`else
`endif
    bus.busy = busy_q;
  end
endmodule
